cache_return_arbiter: RTL and testbench

CACHE_RETURN_ARBITER -- requirements
Module: cache_return_arbiter

---
 rtl/cache_return_pkg.sv | 39 +++
 rtl/cache_return_fifo.sv | 68 ++++++
 rtl/cache_return_arbiter.sv | 166 ++++++++++++++++
 tb/tb_cache_return_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_return_pkg.sv
// ---------------------------------------------------------------------------
// cache_return_pkg
//   Shared definitions for the cache return arbiter: parameter defaults,
//   the buffered entry layout and a small select-width helper.
//   XLEN and CACHE_USER_W fall back to 32 and 4 when the build does not
//   define them.
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif
`ifndef CACHE_USER_W
`define CACHE_USER_W 4
`endif

package cache_return_pkg;

    localparam int DEF_NCH    = 2;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_DATA_W = 2 * `XLEN;
    localparam int DEF_ID_W   = 8;
    localparam int DEF_USER_W = `CACHE_USER_W;
    localparam int ERROR_W    = 6;

    // One buffered return beat. Field widths follow the package defaults;
    // the arbiter's width parameters are expected to match them.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] rdata;
        logic [DEF_ID_W-1:0]   id;
        logic [DEF_USER_W-1:0] user;
        logic [ERROR_W-1:0]    error;
        logic                  mmio;
    } entry_t;

    // Width of a channel index; a single channel still gets one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_return_fifo.sv
// ---------------------------------------------------------------------------
// cache_return_fifo
//   Per-channel DEPTH-entry FIFO of entry_t beats with the head exposed
//   combinationally. The caller must never push when full or pop when empty.
//
//   Ports:
//     clk_i    clock
//     srstn_i  synchronous active-low reset (clears pointers and count)
//     push_i   write wdata_i at the tail
//     pop_i    retire the head entry
//     wdata_i  entry to write
//     head_o   current head entry (valid when ~empty_o)
//     full_o   count == DEPTH (registered state only)
//     empty_o  count == 0
// ---------------------------------------------------------------------------
module cache_return_fifo
    import cache_return_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic   clk_i,
    input  logic   srstn_i,
    input  logic   push_i,
    input  logic   pop_i,
    input  entry_t wdata_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    entry_t           mem_q [DEPTH];

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (!srstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on overflow.
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read
    // after it was written, and leaving it out keeps it plain RAM.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/cache_return_arbiter.sv
// ---------------------------------------------------------------------------
// cache_return_arbiter
//   Merges NCH cache return channels into one valid/ready return stream.
//   Each channel has its own FIFO; a round-robin arbiter feeds a registered
//   output stage. Beats arriving at a full FIFO are dropped and flagged in
//   a sticky per-channel overflow bit.
//
//   Optional feature: define CACHE_RETURN_MMIO_PRIO_EN to grant channels
//   whose head beat has mmio=1 ahead of all others (round-robin among them).
//   Without it, mmio is carried as payload only.
//
//   Ports:
//     clk_i, srstn_i           clock, synchronous active-low reset
//     ch_valid_i / ch_ready_o  per-channel handshake (ready = FIFO not full)
//     ch_rdata_i, ch_id_i,     per-channel payload, packed channel-major
//     ch_user_i, ch_error_i,
//     ch_mmio_i
//     valid_o / ready_i        merged return handshake
//     rdata_o, id_o, user_o,   merged payload
//     error_o, mmio_o
//     ch_o                     source channel of the merged beat
//     overflow_o               sticky per-channel drop flag
// ---------------------------------------------------------------------------
module cache_return_arbiter
    import cache_return_pkg::*;
#(
    parameter  int NCH    = DEF_NCH,
    parameter  int DEPTH  = DEF_DEPTH,
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int ID_W   = DEF_ID_W,
    parameter  int USER_W = DEF_USER_W,
    localparam int CH_W   = sel_w(NCH)
) (
    input  logic                  clk_i,
    input  logic                  srstn_i,
    input  logic [NCH-1:0]        ch_valid_i,
    output logic [NCH-1:0]        ch_ready_o,
    input  logic [NCH*DATA_W-1:0] ch_rdata_i,
    input  logic [NCH*ID_W-1:0]   ch_id_i,
    input  logic [NCH*USER_W-1:0] ch_user_i,
    input  logic [NCH*6-1:0]      ch_error_i,
    input  logic [NCH-1:0]        ch_mmio_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [ID_W-1:0]       id_o,
    output logic [USER_W-1:0]     user_o,
    output logic [5:0]            error_o,
    output logic                  mmio_o,
    output logic [CH_W-1:0]       ch_o,
    output logic [NCH-1:0]        overflow_o
);

    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;
    logic [NCH-1:0] full;
    logic [NCH-1:0] empty;
    entry_t         wdata [NCH];
    entry_t         head  [NCH];

    logic [NCH-1:0]  req;
    logic            found;
    logic [CH_W-1:0] grant;
    logic [CH_W-1:0] cand;
    logic            load;

    logic            valid_q;
    entry_t          out_q;
    logic [CH_W-1:0] ch_q;
    logic [CH_W-1:0] last_grant_q;
    logic [NCH-1:0]  overflow_q;

    // ---------------------------------------------------------------- FIFOs
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign wdata[c] = '{
            rdata: ch_rdata_i[c*DATA_W +: DATA_W],
            id:    ch_id_i[c*ID_W +: ID_W],
            user:  ch_user_i[c*USER_W +: USER_W],
            error: ch_error_i[c*6 +: 6],
            mmio:  ch_mmio_i[c]
        };

        // Ready comes from the registered count only, so a same-cycle pop
        // never opens a slot in a full FIFO.
        assign push[c] = ch_valid_i[c] & ~full[c];
        assign pop[c]  = load & found & (grant == CH_W'(c));

        cache_return_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .srstn_i (srstn_i),
            .push_i  (push[c]),
            .pop_i   (pop[c]),
            .wdata_i (wdata[c]),
            .head_o  (head[c]),
            .full_o  (full[c]),
            .empty_o (empty[c])
        );
    end

    assign ch_ready_o = ~full;

    // -------------------------------------------------------------- arbiter
    // The output stage accepts a new beat when it is empty or its current
    // beat is leaving this cycle.
    assign load = ~valid_q | ready_i;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        req   = ~empty;
        found = 1'b0;
        grant = '0;
        cand  = '0;
`ifdef CACHE_RETURN_MMIO_PRIO_EN
        begin
            logic [NCH-1:0] mmio_req;
            mmio_req = '0;
            for (int i = 0; i < NCH; i++) begin
                mmio_req[i] = ~empty[i] & head[i].mmio;
            end
            if (|mmio_req) req = mmio_req;
        end
`endif
        // Search starts one past the last granted channel.
        for (int i = 0; i < NCH; i++) begin
            cand = CH_W'((int'(last_grant_q) + 1 + i) % NCH);
            if (!found && req[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // --------------------------------------------------------- output stage
    always_ff @(posedge clk_i) begin
        if (!srstn_i) begin
            valid_q      <= 1'b0;
            out_q        <= '0;
            ch_q         <= '0;
            last_grant_q <= CH_W'(NCH - 1);
            overflow_q   <= '0;
        end else begin
            overflow_q <= overflow_q | (ch_valid_i & full);
            if (load) begin
                valid_q <= found;
                if (found) begin
                    out_q        <= head[grant];
                    ch_q         <= grant;
                    last_grant_q <= grant;
                end
            end
        end
    end

    assign valid_o    = valid_q;
    assign rdata_o    = out_q.rdata;
    assign id_o       = out_q.id;
    assign user_o     = out_q.user;
    assign error_o    = out_q.error;
    assign mmio_o     = out_q.mmio;
    assign ch_o       = ch_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_cache_return_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_cache_return_arbiter
//   Self-checking bench: a queue-based model of the arbiter is stepped once
//   per clock alongside the DUT and compared every cycle, plus literal
//   expectations for the directed scenarios.
// ---------------------------------------------------------------------------
module tb_cache_return_arbiter;

    localparam int NCH    = 2;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;
    localparam int ID_W   = 8;
    localparam int USER_W = 4;
    localparam int CH_W   = 1;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic [ID_W-1:0]   id;
        logic [USER_W-1:0] user;
        logic [5:0]        error;
        logic              mmio;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  srstn;
    logic [NCH-1:0]        ch_valid;
    logic [NCH-1:0]        ch_ready;
    logic [NCH*DATA_W-1:0] ch_rdata;
    logic [NCH*ID_W-1:0]   ch_id;
    logic [NCH*USER_W-1:0] ch_user;
    logic [NCH*6-1:0]      ch_error;
    logic [NCH-1:0]        ch_mmio;
    logic                  valid_o;
    logic                  ready;
    logic [DATA_W-1:0]     rdata_o;
    logic [ID_W-1:0]       id_o;
    logic [USER_W-1:0]     user_o;
    logic [5:0]            error_o;
    logic                  mmio_o;
    logic [CH_W-1:0]       ch_o;
    logic [NCH-1:0]        overflow_o;

    beat_t drv [NCH];

    always #5 clk = ~clk;

    always_comb begin
        ch_rdata = '0;
        ch_id    = '0;
        ch_user  = '0;
        ch_error = '0;
        ch_mmio  = '0;
        for (int c = 0; c < NCH; c++) begin
            ch_rdata[c*DATA_W +: DATA_W] = drv[c].rdata;
            ch_id[c*ID_W +: ID_W]        = drv[c].id;
            ch_user[c*USER_W +: USER_W]  = drv[c].user;
            ch_error[c*6 +: 6]           = drv[c].error;
            ch_mmio[c]                   = drv[c].mmio;
        end
    end

    cache_return_arbiter #(
        .NCH    (NCH),
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ID_W   (ID_W),
        .USER_W (USER_W)
    ) dut (
        .clk_i      (clk),
        .srstn_i    (srstn),
        .ch_valid_i (ch_valid),
        .ch_ready_o (ch_ready),
        .ch_rdata_i (ch_rdata),
        .ch_id_i    (ch_id),
        .ch_user_i  (ch_user),
        .ch_error_i (ch_error),
        .ch_mmio_i  (ch_mmio),
        .valid_o    (valid_o),
        .ready_i    (ready),
        .rdata_o    (rdata_o),
        .id_o       (id_o),
        .user_o     (user_o),
        .error_o    (error_o),
        .mmio_o     (mmio_o),
        .ch_o       (ch_o),
        .overflow_o (overflow_o)
    );

    // ------------------------------------------------------------- checking
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    beat_t          mq [NCH][$];
    bit             m_valid;
    beat_t          m_out;
    int             m_ch;
    int             m_last;
    bit [NCH-1:0]   m_ovf;

    // Advances the model by one clock edge using the inputs now applied.
    task automatic model_step();
        bit [NCH-1:0] room;
        bit           mmio_any;
        int           g;
        if (!srstn) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            m_valid = 0;
            m_out   = '0;
            m_ch    = 0;
            m_last  = NCH - 1;
            m_ovf   = '0;
            return;
        end
        for (int c = 0; c < NCH; c++) room[c] = (mq[c].size() < DEPTH);
        if (!m_valid || ready) begin
            mmio_any = 0;
`ifdef CACHE_RETURN_MMIO_PRIO_EN
            for (int c = 0; c < NCH; c++)
                if (mq[c].size() > 0 && mq[c][0].mmio) mmio_any = 1;
`endif
            g = -1;
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (m_last + k) % NCH;
                if (g < 0 && mq[c].size() > 0 && (!mmio_any || mq[c][0].mmio)) g = c;
            end
            if (g >= 0) begin
                m_valid = 1;
                m_out   = mq[g].pop_front();
                m_ch    = g;
                m_last  = g;
            end else begin
                m_valid = 0;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (ch_valid[c]) begin
                if (room[c]) mq[c].push_back(drv[c]);
                else         m_ovf[c] = 1;
            end
        end
    endtask

    task automatic compare();
        logic [NCH-1:0] exp_rdy;
        for (int c = 0; c < NCH; c++) exp_rdy[c] = (mq[c].size() != DEPTH);
        check("valid_o", 64'(valid_o), 64'(m_valid));
        check("ch_ready_o", 64'(ch_ready), 64'(exp_rdy));
        check("overflow_o", 64'(overflow_o), 64'(m_ovf));
        if (m_valid) begin
            check("rdata_o", rdata_o, m_out.rdata);
            check("id_o", 64'(id_o), 64'(m_out.id));
            check("user_o", 64'(user_o), 64'(m_out.user));
            check("error_o", 64'(error_o), 64'(m_out.error));
            check("mmio_o", 64'(mmio_o), 64'(m_out.mmio));
            check("ch_o", 64'(ch_o), 64'(m_ch));
        end
    endtask

    // One clock: model and DUT advance together, outputs compared mid-cycle.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic clear_inputs();
        ch_valid = '0;
        for (int c = 0; c < NCH; c++) drv[c] = '0;
    endtask

    task automatic set_beat(input int c, input logic [ID_W-1:0] id,
                            input logic [DATA_W-1:0] rdata, input logic mmio);
        ch_valid[c]    = 1'b1;
        drv[c].rdata   = rdata;
        drv[c].id      = id;
        drv[c].user    = USER_W'(c + 1);
        drv[c].error   = 6'(id);
        drv[c].mmio    = mmio;
    endtask

    // -------------------------------------------------------------- stimulus
    logic [ID_W-1:0]   held_id;
    logic [DATA_W-1:0] held_rdata;
    int                ch_seq [$];
    logic [ID_W-1:0]   drain_ids [4];

    initial begin
        srstn = 1'b0;
        ready = 1'b0;
        clear_inputs();
        drain_ids[0] = 8'd1;
        drain_ids[1] = 8'd2;
        drain_ids[2] = 8'd3;
        drain_ids[3] = 8'd4;

        // Reset state.
        cycle();
        cycle();
        check("rst valid_o", 64'(valid_o), 64'd0);
        check("rst ch_ready_o", 64'(ch_ready), 64'h3);
        check("rst overflow_o", 64'(overflow_o), 64'd0);
        check("rst ch_o", 64'(ch_o), 64'd0);
        check("rst id_o", 64'(id_o), 64'd0);
        check("rst rdata_o", rdata_o, 64'd0);
        srstn = 1'b1;

        // Single beat, one-cycle latency.
        ready = 1'b1;
        set_beat(0, 8'h12, 64'hAB, 1'b0);
        cycle();
        clear_inputs();
        check("single not yet valid", 64'(valid_o), 64'd0);
        cycle();
        check("single valid_o", 64'(valid_o), 64'd1);
        check("single id_o", 64'(id_o), 64'h12);
        check("single rdata_o", rdata_o, 64'hAB);
        check("single ch_o", 64'(ch_o), 64'd0);
        cycle();

        // Occupy output stage with a ch1 beat, then overfill ch0.
        ready = 1'b0;
        set_beat(1, 8'h40, 64'h4040, 1'b0);
        cycle();
        clear_inputs();
        cycle();
        held_id    = id_o;
        held_rdata = rdata_o;
        check("stall id loaded", 64'(held_id), 64'h40);
        for (int k = 1; k <= 5; k++) begin
            set_beat(0, ID_W'(k), 64'(k * 16'h1111), 1'b0);
            cycle();
            if (k == 3) begin
                check("stall valid_o", 64'(valid_o), 64'd1);
                check("stall id_o", 64'(id_o), 64'(held_id));
                check("stall rdata_o", rdata_o, held_rdata);
            end
            if (k == 4) check("full ch_ready_o[0]", 64'(ch_ready[0]), 64'd0);
        end
        clear_inputs();
        check("overflow_o[0]", 64'(overflow_o[0]), 64'd1);
        check("overflow_o[1]", 64'(overflow_o[1]), 64'd0);
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("drain id_o", 64'(id_o), 64'(drain_ids[k]));
        end
        cycle();
        check("drained valid_o", 64'(valid_o), 64'd0);

        // Reset with beats buffered.
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_beat(0, ID_W'(7 + k), 64'(k), 1'b0);
            cycle();
        end
        clear_inputs();
        srstn = 1'b0;
        cycle();
        check("midrst valid_o", 64'(valid_o), 64'd0);
        check("midrst overflow_o", 64'(overflow_o), 64'd0);
        srstn = 1'b1;
        cycle();
        check("post-rst ch_ready_o", 64'(ch_ready), 64'h3);

        // MMIO head on ch1, plain head on ch0, last_grant = 1 after reset.
        set_beat(0, 8'h50, 64'h50, 1'b0);
        set_beat(1, 8'h51, 64'h51, 1'b1);
        cycle();
        clear_inputs();
        cycle();
`ifdef CACHE_RETURN_MMIO_PRIO_EN
        check("mmio prio ch_o", 64'(ch_o), 64'd1);
`else
        check("pure rr ch_o", 64'(ch_o), 64'd0);
`endif
        ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle();

        // Both channels streaming with ready held high.
        srstn = 1'b0;
        cycle();
        srstn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_beat(0, ID_W'(k), 64'(k), 1'b0);
            set_beat(1, ID_W'(8'h80 + k), 64'(k + 100), 1'b0);
            cycle();
            if (valid_o) ch_seq.push_back(int'(ch_o));
        end
        clear_inputs();
        check("stream ch #0", 64'(ch_seq[0]), 64'd0);
        check("stream ch #1", 64'(ch_seq[1]), 64'd1);
        check("stream ch #2", 64'(ch_seq[2]), 64'd0);
        check("stream ch #3", 64'(ch_seq[3]), 64'd1);
        for (int k = 0; k < 12; k++) cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            srstn = ($urandom_range(0, 599) != 0);
            ready = ($urandom_range(0, 3) != 0);
            clear_inputs();
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 1) == 1)
                    set_beat(c, ID_W'($urandom), {$urandom, $urandom}, 1'($urandom));
            end
            cycle();
        end
        clear_inputs();
        srstn = 1'b1;
        ready = 1'b1;
        for (int k = 0; k < 12; k++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
